seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Time-multiplexed driver for the board's 8-digit common-anode 7-segment display.
//  Consumes the 32-bit SEVENSEGHEX word produced by the processor wrapper (memory content at DIP address).
//  Shows it as 8 hex digits. Sits between the wrapper and the TOP-level anode/cathode pins.
//  Latches input once per frame: no tearing. Inserts per-digit dead time: no ghosting.
// PARAMETERS
//  N_DIGITS     8     number of digits; HEX_IN width = 4*N_DIGITS
//  REFRESH_DIV  1000  CLK cycles per digit slot (>= 2)
//  DEADTIME     4     cycles at start of each slot with all anodes off (0 <= DEADTIME < REFRESH_DIV)
// PORTS
//  CLK       in   1           divided clock from TOP
//  RESET     in   1           synchronous, active-high
//  HEX_IN    in   4*N_DIGITS  value to display; digit k = HEX_IN[4k+3:4k], digit 0 rightmost
//  DP_IN     in   N_DIGITS    decimal point per digit, 1 = lit
//  BLANK_LZ  in   1           1 = blank leading zero digits (digit 0 never blanked)
//  ENABLE    in   1           0 = all anodes off; counters keep running
//  ANODE     out  N_DIGITS    active-low digit enables, one-hot-low or all ones
//  CATHODE   out  7           active-low segments, bit0=a ... bit6=g
//  DP        out  1           active-low decimal point
//  FRAME_TICK out 1           one-cycle pulse, first cycle of each new frame
// BEHAVIOUR
//  Reset: cnt=0, idx=0, shadow=0, shadow_dp=0. ANODE=all 1, CATHODE=7'h7F, DP=1, FRAME_TICK=0.
//  Prescaler cnt: 0..REFRESH_DIV-1, then wraps to 0. On wrap, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
//  Frame boundary: cycle with cnt==REFRESH_DIV-1 && idx==N_DIGITS-1.
//   - Same edge: shadow<=HEX_IN, shadow_dp<=DP_IN, BLANK_LZ sampled.
//   - FRAME_TICK=1 in the following cycle (cnt=0, idx=0).
//  Mid-frame HEX_IN/DP_IN/BLANK_LZ changes have no visible effect until the next boundary.
//  Outputs are registered, with 1 cycle latency from (cnt, idx, shadow):
//   - cnt < DEADTIME or ENABLE==0: ANODE=all 1, CATHODE=7'h7F, DP=1.
//   - blanked digit: ANODE[idx]=0, CATHODE=7'h7F, DP=~shadow_dp[idx].
//   - else: ANODE[idx]=0, others 1, CATHODE=seg(shadow nibble idx), DP=~shadow_dp[idx].
//  Leading-zero blanking: digit k is blanked iff BLANK_LZ latched=1, k>0, and shadow digits k..N_DIGITS-1 are all 0.
//   - DP still follows shadow_dp when the digit is blanked.
//  seg() table (hex, active low):
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
//  ENABLE toggling: effect visible 1 cycle later; cnt/idx/shadow are unaffected.
//  RESET mid-frame: next edge returns everything to reset values; display resumes at digit 0, shadow=0.
//   - First real data is shown from the second frame after reset.
//  ANODE never has more than one bit low in any cycle.
// STRUCTURE
//  Shared package/header: SEG_BLANK=7'h7F, the 16-entry seg table constants, N_DIGITS default.
//  Sub-module hex_to_7seg: combinational nibble -> 7-bit active-low segments.
//  Top level holds the prescaler, digit index, shadow registers, LZ mask logic and output registers.
// TESTING (bench: REFRESH_DIV=4, DEADTIME=1, N_DIGITS=8)
//  Reset, then HEX_IN=32'h0000_0000, BLANK_LZ=0 -> ANODE=FF for the first cycle after reset.
//   - Then per slot: 1 cycle FF, 3 cycles one-hot-low walking FE,FD,..,7F, CATHODE=40.
//   - Period 32 cycles.
//  HEX_IN=32'h1234_ABCD held over a boundary -> next frame digit0..7 CATHODE = 21,46,03,08,19,30,24,79.
//   - FRAME_TICK pulses once per 32 cycles.
//  BLANK_LZ=1, HEX_IN=32'h0000_0830 -> digits 3..7 CATHODE=7F with their anode low; digits 0..2 = 40,30,00.
//   - HEX_IN=0 -> only digit 0 shows 40.
//  HEX_IN changed 5'h from 11111111 to 22222222 at idx=3 -> rest of frame shows 79; next frame shows 24.
//  DP_IN=8'h04 -> DP=0 only while ANODE=FB (outside dead time); ENABLE=0 for 10 cycles -> ANODE=FF.
//   - FRAME_TICK spacing unchanged.
//  RESET asserted at idx=5, cnt=2 for 1 cycle -> next cycle outputs at reset values.
//   - Scan restarts from digit 0; shadow reads 0 until the first boundary.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the 8-digit 7-segment scanner: segment encodings and default digit count.
package seven_seg_scanner_pkg;

    localparam int N_DIGITS_DEFAULT = 8;

    // Active-low segments, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seven_seg_scanner_hex_to_7seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver with per-frame input latch and per-slot dead time.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int N_DIGITS    = N_DIGITS_DEFAULT,
    parameter int REFRESH_DIV = 1000,
    parameter int DEADTIME    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [N_DIGITS-1:0]   anode,
    output logic [6:0]            cathode,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // Slot timer counts down: tmr == REFRESH_DIV-1-cnt, so tmr == 0 is the last cycle of a slot.
    logic [CW-1:0]         tmr;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] shadow;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  blank_lz_q;

    logic                  slot_end;
    logic                  last_digit;
    logic                  frame_end;
    logic                  dead_time;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg;
    logic [N_DIGITS-1:0]   blank_mask;
    logic                  zero_above;

    assign slot_end   = (tmr == '0);
    assign last_digit = (idx == IW'(N_DIGITS - 1));
    assign frame_end  = slot_end && last_digit;
    assign dead_time  = (32'(tmr) > 32'(REFRESH_DIV - 1 - DEADTIME));
    assign cur_nibble = shadow[{idx, 2'b00} +: 4];

    seven_seg_scanner_hex_to_7seg u_hex_to_7seg (
        .nibble   (cur_nibble),
        .segments (cur_seg)
    );

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        zero_above = 1'b1;
        blank_mask = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above    = zero_above && (shadow[4*k +: 4] == 4'h0);
            blank_mask[k] = blank_lz_q && (k != 0) && zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr        <= CW'(REFRESH_DIV - 1);
            idx        <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            blank_lz_q <= 1'b0;
        end else begin
            if (slot_end) begin
                tmr <= CW'(REFRESH_DIV - 1);
                idx <= last_digit ? '0 : idx + 1'b1;
            end else begin
                tmr <= tmr - 1'b1;
            end
            if (frame_end) begin
                shadow     <= hex_in;
                shadow_dp  <= dp_in;
                blank_lz_q <= blank_lz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anode      <= '1;
            cathode    <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (dead_time || !enable) begin
                anode   <= '1;
                cathode <= SEG_BLANK;
                dp      <= 1'b1;
            end else begin
                anode   <= ~(N_DIGITS'(1) << idx);
                cathode <= blank_mask[idx] ? SEG_BLANK : cur_seg;
                dp      <= ~shadow_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: cycle-position reference model feeds a queue, a negedge monitor compares.
module tb_seven_seg_scanner;

    localparam int N     = 8;
    localparam int RD    = 4;
    localparam int DT    = 1;
    localparam int FRAME = N * RD;

    typedef struct packed {
        logic [7:0] anode;
        logic [6:0] cathode;
        logic       dp;
        logic       frame_tick;
    } out_t;

    localparam out_t RESET_OUT = '{anode: 8'hFF, cathode: 7'h7F, dp: 1'b1, frame_tick: 1'b0};

    logic        clk;
    logic        reset;
    logic [31:0] hex_in;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic        enable;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] exp_abcd [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] exp_lz   [8] = '{7'h40, 7'h30, 7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] exp_zero [8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    seven_seg_scanner #(
        .N_DIGITS    (N),
        .REFRESH_DIV (RD),
        .DEADTIME    (DT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .anode      (anode),
        .cathode    (cathode),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position p cycles after reset lies in slot p/RD, digit (p/RD)%N, offset p%RD.
    int          t;
    logic [31:0] m_shadow;
    logic [7:0]  m_dp;
    logic        m_blank;
    out_t        exp_q [$];

    function automatic out_t model_out(int pos, logic en, logic [31:0] sh, logic [7:0] sdp, logic blz);
        out_t o;
        int   offs;
        int   digit;
        logic [31:0] upper;
        offs  = pos % RD;
        digit = (pos / RD) % N;
        upper = sh >> (4 * digit);
        o.frame_tick = ((pos % FRAME) == FRAME - 1);
        if (offs < DT || !en) begin
            o.anode   = 8'hFF;
            o.cathode = 7'h7F;
            o.dp      = 1'b1;
        end else begin
            o.anode        = 8'hFF;
            o.anode[digit] = 1'b0;
            o.cathode      = (blz && digit != 0 && upper == 32'd0) ? 7'h7F : seg_ref[upper[3:0]];
            o.dp           = ~sdp[digit];
        end
        return o;
    endfunction

    initial begin
        t = 0;
        m_shadow = '0;
        m_dp = '0;
        m_blank = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.push_back(RESET_OUT);
                t = 0;
                m_shadow = '0;
                m_dp = '0;
                m_blank = 1'b0;
            end else begin
                exp_q.push_back(model_out(t, enable, m_shadow, m_dp, m_blank));
                if ((t % FRAME) == FRAME - 1) begin
                    m_shadow = hex_in;
                    m_dp = dp_in;
                    m_blank = blank_lz;
                end
                t = t + 1;
            end
        end
    end

    initial begin
        out_t e;
        out_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{anode: anode, cathode: cathode, dp: dp, frame_tick: frame_tick};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL out @%0t: got anode=%h cat=%h dp=%b tick=%b, expected anode=%h cat=%h dp=%b tick=%b",
                             $time, got.anode, got.cathode, got.dp, got.frame_tick,
                             e.anode, e.cathode, e.dp, e.frame_tick);
                end
                n_tests++;
                if ($countones(~anode) > 1) begin
                    n_fail++;
                    $display("FAIL anode_onehot @%0t: got anode=%h, expected at most one low bit", $time, anode);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Record the cathode seen while each digit's anode is low over one full frame.
    task automatic capture_frame(output logic [6:0] cat [8]);
        for (int k = 0; k < 8; k++) cat[k] = 7'h7F;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++)
                if (anode == ~(8'h01 << k)) cat[k] = cathode;
        end
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != p; i++) @(negedge clk);
        check("align", 32'(t % FRAME), 32'(p));
    endtask

    logic [6:0] cat [8];
    int ticks;

    initial begin
        reset = 1'b1; hex_in = '0; dp_in = '0; blank_lz = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        hex_in = 32'h1234_ABCD;
        repeat (70) @(negedge clk);
        capture_frame(cat);
        for (int k = 0; k < 8; k++) check("digit_abcd", 32'(cat[k]), 32'(exp_abcd[k]));

        blank_lz = 1'b1; hex_in = 32'h0000_0830;
        repeat (70) @(negedge clk);
        capture_frame(cat);
        for (int k = 0; k < 8; k++) check("digit_lz", 32'(cat[k]), 32'(exp_lz[k]));
        hex_in = 32'h0;
        repeat (70) @(negedge clk);
        capture_frame(cat);
        for (int k = 0; k < 8; k++) check("digit_zero", 32'(cat[k]), 32'(exp_zero[k]));

        blank_lz = 1'b0; hex_in = 32'h1111_1111;
        repeat (70) @(negedge clk);
        wait_pos(13);
        hex_in = 32'h2222_2222;
        repeat (70) @(negedge clk);

        dp_in = 8'h04; hex_in = $urandom;
        repeat (70) @(negedge clk);
        ticks = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            if (frame_tick) ticks++;
            if (c == 20) enable = 1'b0;
            if (c == 30) enable = 1'b1;
        end
        check("tick_count", 32'(ticks), 32'd3);

        hex_in = 32'h5A5A_0F0F;
        wait_pos(22);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);

        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(7) == 0) hex_in = $urandom;
            if ($urandom_range(7) == 0) hex_in = $urandom & 32'h0000_0FFF;
            if ($urandom_range(7) == 0) dp_in = 8'($urandom);
            if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(15) == 0) enable = ~enable;
            reset = ($urandom_range(299) == 0);
            @(negedge clk);
        end
        reset = 1'b0; enable = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
